ft6206_target_model: RTL and testbench

- Synthesizable I2C target (responder) emulating the FT6206 capacitive touch controller at 7-bit address 0x38.
- Serves the register subset used by our FT6206 initiator: TD_STATUS, P1_XH/XL/YH/YL and the threshold register.
- Touch data is sourced from fabric inputs (switches, test pattern, or bench).
- Used for on-board loopback and simulation of the etch-a-sketch touch path without a panel.

---
 rtl/ft6206_target_model.sv | 259 +++++++++++++++++++++++++
 tb/tb_ft6206_target_model.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ft6206_target_model.sv
// ft6206_target_model
// I2C target that stands in for an FT6206 capacitive touch controller.
// It serves TD_STATUS (0x02), the touch-1 X/Y registers (0x03..0x06) and the
// threshold register (0x80). Touch data comes from fabric inputs. The touch
// bytes are captured once per read address phase, so a read burst is coherent.
//
// Ports:
//   clk           system clock, at least 20x the SCL rate
//   rst           asynchronous active-high reset
//   scl           I2C clock from the initiator (never stretched here)
//   sda           open-drain data line; this block drives only 0 or Z
//   touch_status  TD_STATUS[3:0]
//   p1_event      P1_XH[7:6]
//   p1_x          touch 1 X coordinate (12 bits)
//   p1_id         P1_YH[7:4]
//   p1_y          touch 1 Y coordinate (12 bits)
//   threshold     current threshold register value
//   threshold_wr  one-cycle pulse after a threshold write
//   busy          high from address match until STOP, START or read NACK
module ft6206_target_model #(
  parameter logic [6:0] ADDRESS           = 7'h38,
  parameter logic [7:0] DEFAULT_THRESHOLD = 8'd128,
  parameter int         SYNC_STAGES       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  input  logic [3:0]  touch_status,
  input  logic [1:0]  p1_event,
  input  logic [11:0] p1_x,
  input  logic [3:0]  p1_id,
  input  logic [11:0] p1_y,
  output logic [7:0]  threshold,
  output logic        threshold_wr,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_t;

  // Register-map decode; the touch bytes come from the snapshot, not live inputs.
  function automatic logic [7:0] reg_byte(input logic [7:0]  ptr,
                                          input logic [39:0] snap,
                                          input logic [7:0]  thr);
    logic [7:0] b;
    case (ptr)
      8'h02:   b = snap[39:32];
      8'h03:   b = snap[31:24];
      8'h04:   b = snap[23:16];
      8'h05:   b = snap[15:8];
      8'h06:   b = snap[7:0];
      8'h80:   b = thr;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic        scl_prev_r, sda_prev_r;
  logic        scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  state_t      state_r, state_nxt_s;
  logic [3:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]  shift_r, shift_nxt_s, rx_byte_s;
  logic        rw_r, rw_nxt_s;
  logic [7:0]  reg_ptr_r, reg_ptr_nxt_s;
  logic [7:0]  tx_r, tx_nxt_s, cur_byte_s, next_byte_s;
  logic        sda_oe_r, sda_oe_nxt_s;
  logic [7:0]  threshold_r, threshold_nxt_s;
  logic        threshold_wr_r, threshold_wr_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic [39:0] snap_r, snap_nxt_s, live_snap_s;

  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  // Bus conditions need scl high on both sides of the sda edge.
  assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
  assign rx_byte_s  = {shift_r[6:0], sda_s};
  assign cur_byte_s  = reg_byte(reg_ptr_r, snap_r, threshold_r);
  assign next_byte_s = reg_byte(reg_ptr_r + 8'd1, snap_r, threshold_r);
  assign live_snap_s = {4'h0, touch_status, p1_event, 2'b00, p1_x[11:8],
                        p1_x[7:0], p1_id, p1_y[11:8], p1_y[7:0]};

  assign sda          = sda_oe_r ? 1'b0 : 1'bz;
  assign threshold    = threshold_r;
  assign threshold_wr = threshold_wr_r;
  assign busy         = busy_r;

  // Input synchronizers and previous-value flops for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  // Next-state and datapath: bus conditions take priority over bit handling.
  always_comb begin
    state_nxt_s        = state_r;
    bit_cnt_nxt_s      = bit_cnt_r;
    shift_nxt_s        = shift_r;
    rw_nxt_s           = rw_r;
    reg_ptr_nxt_s      = reg_ptr_r;
    tx_nxt_s           = tx_r;
    sda_oe_nxt_s       = sda_oe_r;
    threshold_nxt_s    = threshold_r;
    threshold_wr_nxt_s = 1'b0;
    busy_nxt_s         = busy_r;
    snap_nxt_s         = snap_r;
    if (start_s) begin
      state_nxt_s   = S_ADDR;
      bit_cnt_nxt_s = 4'd0;
      sda_oe_nxt_s  = 1'b0;
      busy_nxt_s    = 1'b0;
    end else if (stop_s) begin
      state_nxt_s   = S_IDLE;
      bit_cnt_nxt_s = 4'd0;
      sda_oe_nxt_s  = 1'b0;
      busy_nxt_s    = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          sda_oe_nxt_s = 1'b0;
        end
        S_ADDR, S_REG, S_WDATA: begin
          if (scl_rise_s) begin
            shift_nxt_s = rx_byte_s;
            if (bit_cnt_r == 4'd7) begin
              bit_cnt_nxt_s = 4'd0;
              if (state_r == S_ADDR) begin
                if (rx_byte_s[7:1] == ADDRESS) begin
                  state_nxt_s = S_ADDR_ACK;
                  rw_nxt_s    = rx_byte_s[0];
                  busy_nxt_s  = 1'b1;
                  snap_nxt_s  = rx_byte_s[0] ? live_snap_s : snap_r;
                end else begin
                  state_nxt_s = S_IDLE;
                end
              end else if (state_r == S_REG) begin
                reg_ptr_nxt_s = rx_byte_s;
                state_nxt_s   = S_REG_ACK;
              end else begin
                if (reg_ptr_r == 8'h80) begin
                  threshold_nxt_s    = rx_byte_s;
                  threshold_wr_nxt_s = 1'b1;
                end else begin
                  threshold_nxt_s = threshold_r;
                end
                reg_ptr_nxt_s = reg_ptr_r + 8'd1;
                state_nxt_s   = S_WDATA_ACK;
              end
            end else begin
              bit_cnt_nxt_s = bit_cnt_r + 4'd1;
            end
          end else begin
            shift_nxt_s = shift_r;
          end
        end
        // bit_cnt 0: the next falling edge starts the ACK; 1: it ends the ACK.
        S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
          if (scl_fall_s) begin
            if (bit_cnt_r == 4'd0) begin
              sda_oe_nxt_s  = 1'b1;
              bit_cnt_nxt_s = 4'd1;
            end else if ((state_r == S_ADDR_ACK) && rw_r) begin
              sda_oe_nxt_s  = ~cur_byte_s[7];
              tx_nxt_s      = {cur_byte_s[6:0], 1'b0};
              bit_cnt_nxt_s = 4'd1;
              state_nxt_s   = S_RDATA;
            end else begin
              sda_oe_nxt_s  = 1'b0;
              bit_cnt_nxt_s = 4'd0;
              state_nxt_s   = (state_r == S_ADDR_ACK) ? S_REG : S_WDATA;
            end
          end else begin
            sda_oe_nxt_s = sda_oe_r;
          end
        end
        // bit_cnt counts bits already placed on the line.
        S_RDATA: begin
          if (scl_fall_s) begin
            if (bit_cnt_r == 4'd8) begin
              sda_oe_nxt_s  = 1'b0;
              bit_cnt_nxt_s = 4'd0;
              state_nxt_s   = S_RDATA_ACK;
            end else begin
              sda_oe_nxt_s  = ~tx_r[7];
              tx_nxt_s      = {tx_r[6:0], 1'b0};
              bit_cnt_nxt_s = bit_cnt_r + 4'd1;
            end
          end else begin
            sda_oe_nxt_s = sda_oe_r;
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise_s) begin
            reg_ptr_nxt_s = reg_ptr_r + 8'd1;
            bit_cnt_nxt_s = 4'd0;
            if (!sda_s) begin
              tx_nxt_s    = next_byte_s;
              state_nxt_s = S_RDATA;
            end else begin
              busy_nxt_s  = 1'b0;
              state_nxt_s = S_IDLE;
            end
          end else begin
            reg_ptr_nxt_s = reg_ptr_r;
          end
        end
        default: begin
          state_nxt_s  = S_IDLE;
          sda_oe_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; reset releases sda immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= S_IDLE;
      bit_cnt_r      <= 4'd0;
      shift_r        <= 8'h00;
      rw_r           <= 1'b0;
      reg_ptr_r      <= 8'h00;
      tx_r           <= 8'h00;
      sda_oe_r       <= 1'b0;
      threshold_r    <= DEFAULT_THRESHOLD;
      threshold_wr_r <= 1'b0;
      busy_r         <= 1'b0;
      snap_r         <= 40'h0;
    end else begin
      state_r        <= state_nxt_s;
      bit_cnt_r      <= bit_cnt_nxt_s;
      shift_r        <= shift_nxt_s;
      rw_r           <= rw_nxt_s;
      reg_ptr_r      <= reg_ptr_nxt_s;
      tx_r           <= tx_nxt_s;
      sda_oe_r       <= sda_oe_nxt_s;
      threshold_r    <= threshold_nxt_s;
      threshold_wr_r <= threshold_wr_nxt_s;
      busy_r         <= busy_nxt_s;
      snap_r         <= snap_nxt_s;
    end
  end

endmodule

// File: tb/tb_ft6206_target_model.sv
// tb_ft6206_target_model
// Directed bench for ft6206_target_model: a bit-banged I2C initiator at
// 100 kHz drives the bus; expected bytes are hand-computed from the inputs.
`timescale 1ns/1ps
module tb_ft6206_target_model;
  localparam time CLK_HALF = 125;   // 4 MHz system clock, 40x SCL
  localparam time Q        = 2500;  // quarter SCL period at 100 kHz

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        tb_oe;
  wire         sda;
  logic [3:0]  touch_status;
  logic [1:0]  p1_event;
  logic [11:0] p1_x;
  logic [3:0]  p1_id;
  logic [11:0] p1_y;
  logic [7:0]  threshold;
  logic        threshold_wr;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;
  int drive_cnt = 0;
  int busy_cnt = 0;
  logic mon_en = 1'b0;

  assign sda = tb_oe ? 1'b0 : 1'bz;
  pullup (sda);

  ft6206_target_model dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .touch_status(touch_status), .p1_event(p1_event), .p1_x(p1_x),
    .p1_id(p1_id), .p1_y(p1_y),
    .threshold(threshold), .threshold_wr(threshold_wr), .busy(busy)
  );

  always #CLK_HALF clk = ~clk;

  // Pulse counter and bus monitor, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (threshold_wr) wr_pulses++;
    if (mon_en && !tb_oe && sda == 1'b0) drive_cnt++;
    if (mon_en && busy) busy_cnt++;
  end

  initial begin
    #(20_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    tb_oe = 1'b0; #Q; scl = 1'b1; #Q; tb_oe = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    tb_oe = 1'b1; #Q; scl = 1'b1; #Q; tb_oe = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    tb_oe = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tb_oe = 1'b0; #Q; scl = 1'b1; #Q; ack = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      tb_oe = 1'b0; #Q; scl = 1'b1; #Q; d[i] = sda; #Q; scl = 1'b0; #Q;
    end
    send_bit(nack);
  endtask

  logic       ack;
  logic [7:0] d;
  int         base_a, base_b;

  initial begin
    rst = 1'b1; scl = 1'b1; tb_oe = 1'b0;
    touch_status = 4'h1; p1_event = 2'd2; p1_x = 12'h0A5; p1_id = 4'h0; p1_y = 12'h12C;
    #37;
    #(10*2*CLK_HALF);
    rst = 1'b0;
    #Q;
    check_val("rst_threshold", threshold, 8'h80);
    check_val("rst_thr_wr", {7'h0, threshold_wr}, 8'h00);
    check_val("rst_busy", {7'h0, busy}, 8'h00);
    check_val("rst_sda", {7'h0, sda}, 8'h01);

    // Threshold write: 0x70, 0x80, 0x40
    base_a = wr_pulses;
    i2c_start();
    write_byte(8'h70, ack); check_val("thr_ack_addr", {7'h0, ack}, 8'h00);
    write_byte(8'h80, ack); check_val("thr_ack_reg", {7'h0, ack}, 8'h00);
    write_byte(8'h40, ack); check_val("thr_ack_data", {7'h0, ack}, 8'h00);
    check_val("thr_busy_before_stop", {7'h0, busy}, 8'h01);
    i2c_stop(); #Q;
    check_val("thr_busy_after_stop", {7'h0, busy}, 8'h00);
    check_val("thr_value", threshold, 8'h40);
    check_val("thr_wr_pulses", 8'(wr_pulses - base_a), 8'h01);

    // Burst read from 0x02 with p1_x changed mid-burst
    i2c_start();
    write_byte(8'h70, ack); check_val("rd_ack_addr", {7'h0, ack}, 8'h00);
    write_byte(8'h02, ack); check_val("rd_ack_reg", {7'h0, ack}, 8'h00);
    i2c_start();
    write_byte(8'h71, ack); check_val("rd_ack_addr_r", {7'h0, ack}, 8'h00);
    read_byte(1'b0, d); check_val("rd_b0", d, 8'h01);
    read_byte(1'b0, d); check_val("rd_b1", d, 8'h80);
    p1_x = 12'h3FF;
    read_byte(1'b0, d); check_val("rd_b2_snap", d, 8'hA5);
    read_byte(1'b0, d); check_val("rd_b3_snap", d, 8'h01);
    read_byte(1'b1, d); check_val("rd_b4_snap", d, 8'h2C);
    i2c_stop(); #Q;

    // New transaction sees the updated inputs
    p1_event = 2'd0;
    i2c_start();
    write_byte(8'h70, ack);
    write_byte(8'h03, ack);
    i2c_start();
    write_byte(8'h71, ack);
    read_byte(1'b0, d); check_val("new_xh", d, 8'h03);
    read_byte(1'b1, d); check_val("new_xl", d, 8'hFF);
    i2c_stop(); #Q;

    // Address mismatch: 0x39
    base_a = drive_cnt; base_b = busy_cnt; mon_en = 1'b1;
    i2c_start();
    write_byte(8'h72, ack); check_val("mis_ack_addr", {7'h0, ack}, 8'h01);
    write_byte(8'h02, ack); check_val("mis_ack_next", {7'h0, ack}, 8'h01);
    i2c_stop(); #Q;
    mon_en = 1'b0;
    check_val("mis_sda_driven", 8'(drive_cnt - base_a), 8'h00);
    check_val("mis_busy_seen", 8'(busy_cnt - base_b), 8'h00);

    // Read without register phase continues at 0x05 (pointer persisted)
    i2c_start();
    write_byte(8'h71, ack); check_val("cont_ack", {7'h0, ack}, 8'h00);
    read_byte(1'b1, d); check_val("cont_b05", d, 8'h01);
    i2c_stop(); #Q;

    // Reset while the target drives bit 7 (=0) of register 0x06 (0x2C)
    i2c_start();
    write_byte(8'h71, ack);
    tb_oe = 1'b0; #Q; scl = 1'b1; #(Q/2);
    check_val("rr_sda_driven", {7'h0, sda}, 8'h00);
    rst = 1'b1; #1;
    check_val("rr_sda_released", {7'h0, sda}, 8'h01);
    check_val("rr_threshold", threshold, 8'h80);
    check_val("rr_busy", {7'h0, busy}, 8'h00);
    #(8*2*CLK_HALF);
    rst = 1'b0;
    #Q; scl = 1'b0; #Q;
    i2c_stop(); #Q;

    // Follow-up transactions after reset
    i2c_start();
    write_byte(8'h70, ack); check_val("post_ack_addr", {7'h0, ack}, 8'h00);
    write_byte(8'h80, ack); check_val("post_ack_reg", {7'h0, ack}, 8'h00);
    write_byte(8'h55, ack); check_val("post_ack_data", {7'h0, ack}, 8'h00);
    i2c_stop(); #Q;
    check_val("post_threshold", threshold, 8'h55);
    i2c_start();
    write_byte(8'h70, ack);
    write_byte(8'h80, ack);
    i2c_start();
    write_byte(8'h71, ack);
    read_byte(1'b1, d); check_val("post_thr_read", d, 8'h55);
    i2c_stop(); #Q;

    // Pointer wrap: write data to 0xFF, then read 0x00 and 0x01
    i2c_start();
    write_byte(8'h70, ack);
    write_byte(8'hFF, ack); check_val("wrap_ack_reg", {7'h0, ack}, 8'h00);
    write_byte(8'h12, ack); check_val("wrap_ack_data", {7'h0, ack}, 8'h00);
    i2c_stop(); #Q;
    check_val("wrap_thr_untouched", threshold, 8'h55);
    i2c_start();
    write_byte(8'h71, ack);
    read_byte(1'b0, d); check_val("wrap_b00", d, 8'h00);
    read_byte(1'b1, d); check_val("wrap_b01", d, 8'h00);
    i2c_stop(); #Q;
    touch_status = 4'h9;
    i2c_start();
    write_byte(8'h71, ack);
    read_byte(1'b1, d); check_val("wrap_ptr_is_02", d, 8'h09);
    i2c_stop(); #Q;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
